// File: rtl/iq_stream_pkg.sv
// ---------------------------------------------------------------------------
// iq_stream_pkg
// Shared types and constants for the complex I/Q byte streaming path.
//
// Contents:
//   shift_state_e  - byte shifter state (IDLE, SEND)
//   calc_nbytes()  - bytes per complex word for a given component width
//   SYNC_I/SYNC_Q  - realignment marks written into the top two bits of the
//                    I and Q components when IQ_SYNC_BITS_EN is defined
//   BYTE_W         - width of one output byte
//
// Byte order on the stream is most-significant byte first across the whole
// complex word: I high byte, I low byte, Q high byte, Q low byte.
// ---------------------------------------------------------------------------
package iq_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } shift_state_e;

    localparam int BYTE_W = 8;

    localparam logic [1:0] SYNC_I = 2'b10;
    localparam logic [1:0] SYNC_Q = 2'b01;

    // One complex word carries two components of data_width bits each.
    function automatic int calc_nbytes(input int data_width);
        return (2 * data_width) / BYTE_W;
    endfunction

endpackage

// File: rtl/iq_prefetch_reg.sv
// ---------------------------------------------------------------------------
// iq_prefetch_reg
// One-word prefetch stage between the I/Q FIFO read port and the byte
// shifter. Issues a single read strobe, waits one cycle for the FIFO's
// registered read data, then holds the word until the shifter takes it.
//
// Ports:
//   clk_i        in   FIFO read clock
//   rst_i        in   synchronous active-high reset
//   en_i         in   permits new FIFO reads
//   fifo_empty_i in   FIFO empty flag
//   fifo_data_i  in   FIFO read data, valid the cycle after fifo_rd_en_o
//   take_i       in   shifter consumes pf_word_o this cycle
//   fifo_rd_en_o out  FIFO read strobe
//   pending_o    out  a read has been issued and its data is due now
//   pf_valid_o   out  pf_word_o holds an unconsumed word
//   pf_word_o    out  prefetched complex word
// ---------------------------------------------------------------------------
module iq_prefetch_reg
    import iq_stream_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              fifo_empty_i,
    input  logic [WORD_W-1:0] fifo_data_i,
    input  logic              take_i,
    output logic              fifo_rd_en_o,
    output logic              pending_o,
    output logic              pf_valid_o,
    output logic [WORD_W-1:0] pf_word_o
);

    // A read is only issued when nothing is in flight and the holding
    // register is empty. Because pending follows every read, two reads can
    // never be adjacent, which hides the one-cycle lag of the FIFO's
    // registered empty flag. pf_valid here is the pre-clock value, so a word
    // consumed this cycle only allows the next read one cycle later.
    assign fifo_rd_en_o = en_i && !fifo_empty_i && !pending_o && !pf_valid_o && !rst_i;

    // pending marks the cycle in which the FIFO presents the requested word;
    // that word is captured at the end of the cycle. Capture and consumption
    // can never coincide, since a read is only issued while pf_valid is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_o  <= 1'b0;
            pf_valid_o <= 1'b0;
            pf_word_o  <= '0;
        end else begin
            pending_o <= fifo_rd_en_o;
            if (pending_o) begin
                pf_word_o  <= fifo_data_i;
                pf_valid_o <= 1'b1;
            end else if (take_i) begin
                pf_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iq_byte_serializer.sv
// ---------------------------------------------------------------------------
// iq_byte_serializer
// Pulls complex I/Q words (I upper half, Q lower half) from the dual-clock
// I/Q FIFO read side and emits them as a valid/ready byte stream to the SMI
// transmit logic, most-significant byte first. A one-word prefetch keeps
// bytes flowing back-to-back across word boundaries.
//
// Optional feature macro: IQ_SYNC_BITS_EN
//   When defined, the top two bits of I are forced to SYNC_I and the top two
//   bits of Q to SYNC_Q as each word enters the shift register, so the host
//   can realign after a byte slip. Upstream must sign-compress the samples.
//   When undefined, words pass unmodified.
//
// Ports:
//   clk_i          in   FIFO read clock
//   rst_i          in   synchronous active-high reset
//   en_i           in   permits new FIFO reads
//   fifo_empty_i   in   FIFO empty flag
//   fifo_data_i    in   FIFO read data (2*DATA_WIDTH)
//   fifo_rd_en_o   out  FIFO read strobe, one-cycle pulse
//   byte_o         out  output byte
//   byte_valid_o   out  byte_o is valid
//   byte_ready_i   in   consumer accepts byte_o
//   sample_start_o out  byte_o is byte 0 of a word
//   busy_o         out  a word is held, in flight or being sent
// ---------------------------------------------------------------------------
module iq_byte_serializer
    import iq_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16
)
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    fifo_empty_i,
    input  logic [2*DATA_WIDTH-1:0] fifo_data_i,
    output logic                    fifo_rd_en_o,
    output logic [BYTE_W-1:0]       byte_o,
    output logic                    byte_valid_o,
    input  logic                    byte_ready_i,
    output logic                    sample_start_o,
    output logic                    busy_o
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int NBYTES = calc_nbytes(DATA_WIDTH);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic              pending;
    logic              pf_valid;
    logic [WORD_W-1:0] pf_word;
    logic              take;
    logic [WORD_W-1:0] load_word;
    shift_state_e      state;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              xfer;
    logic              last_byte;

    iq_prefetch_reg #(
        .WORD_W(WORD_W)
    ) u_prefetch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .take_i      (take),
        .fifo_rd_en_o(fifo_rd_en_o),
        .pending_o   (pending),
        .pf_valid_o  (pf_valid),
        .pf_word_o   (pf_word)
    );

    assign xfer      = byte_valid_o && byte_ready_i;
    assign last_byte = (idx == LAST_IDX);

    // The shifter takes the prefetched word either from IDLE or, without a
    // bubble, on the handshake of the final byte of the current word.
    assign take = pf_valid && ((state == IDLE) || (xfer && last_byte));

    // Word as it enters the shift register; with sync marks enabled the two
    // component MSB pairs are overwritten by the realignment pattern.
    always_comb begin
        load_word = pf_word;
`ifdef IQ_SYNC_BITS_EN
        load_word[WORD_W-1 -: 2]     = SYNC_I;
        load_word[DATA_WIDTH-1 -: 2] = SYNC_Q;
`endif
    end

    // The current byte is always the top byte of the shift register; the
    // register shifts left one byte per accepted transfer, so zeros fill in
    // and byte_o returns to zero once the last byte has gone.
    assign byte_o = shreg[WORD_W-1 -: BYTE_W];

    assign busy_o = pending || pf_valid || (state == SEND);

    // Shifter FSM. byte_valid_o and sample_start_o are registered and only
    // change on a load or an accepted transfer, so the presented byte stays
    // stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            shreg          <= '0;
            idx            <= '0;
            byte_valid_o   <= 1'b0;
            sample_start_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pf_valid) begin
                        shreg          <= load_word;
                        idx            <= '0;
                        byte_valid_o   <= 1'b1;
                        sample_start_o <= 1'b1;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last_byte) begin
                            idx <= '0;
                            if (pf_valid) begin
                                shreg          <= load_word;
                                byte_valid_o   <= 1'b1;
                                sample_start_o <= 1'b1;
                            end else begin
                                shreg          <= '0;
                                byte_valid_o   <= 1'b0;
                                sample_start_o <= 1'b0;
                                state          <= IDLE;
                            end
                        end else begin
                            shreg          <= shreg << BYTE_W;
                            idx            <= idx + 1'b1;
                            sample_start_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_iq_byte_serializer
// Self-checking bench for iq_byte_serializer. Models the upstream FIFO as a
// queue and predicts the byte stream from the words pushed into it.
// Honours IQ_SYNC_BITS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_iq_byte_serializer;

    localparam int DATA_WIDTH = 16;
    localparam int NB         = 4;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;
    logic        fifo_rd_en_o;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic        sample_start_o;
    logic        busy_o;

    iq_byte_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_rd_en_o  (fifo_rd_en_o),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid_o),
        .byte_ready_i  (byte_ready_i),
        .sample_start_o(sample_start_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_plain;
        logic [31:0] exp_sync;
    } vec_t;

    vec_t         vecs[5];
    logic [31:0]  fifo_q[$];
    logic [7:0]   exp_q[$];
    int           errors;
    int           checks;
    int           byte_cnt;
    logic         prev_valid;
    logic         prev_ready;
    logic [7:0]   prev_byte;
    logic         prev_rd;
    logic         last_rd;

    // Free-running read clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case a wait somewhere never resolves.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference shaping of one word: the sync marks replace the top two bits
    // of each 16-bit component when the feature is enabled.
    function automatic logic [31:0] shape_word(input logic [31:0] w);
`ifdef IQ_SYNC_BITS_EN
        return {2'b10, w[29:16], 2'b01, w[13:0]};
`else
        return w;
`endif
    endfunction

    task automatic push_word(input logic [31:0] w, input logic [31:0] expw);
        fifo_q.push_back(w);
        fifo_empty_i = 1'b0;
        for (int k = 0; k < NB; k++) exp_q.push_back(expw[31-8*k -: 8]);
    endtask

    // Advance one clock. Observes the cycle's outputs shortly after the
    // falling edge, then plays the FIFO's part at the rising edge.
    task automatic step_cycle();
        logic rd;
        #1;
        if (rst_i) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            if (byte_valid_o && byte_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_byte: actual=%0h required=none", byte_o);
                end else begin
                    checkOutput("byte", {24'd0, byte_o}, {24'd0, exp_q.pop_front()});
                    checkOutput("sample_start", {31'd0, sample_start_o}, {31'd0, (byte_cnt % NB) == 0});
                end
                byte_cnt++;
            end
            if (prev_valid && !prev_ready) begin
                checkOutput("hold_valid", {31'd0, byte_valid_o}, 32'd1);
                checkOutput("hold_byte", {24'd0, byte_o}, {24'd0, prev_byte});
            end
            if (prev_rd) checkOutput("rd_gap", {31'd0, fifo_rd_en_o}, 32'd0);
            if (!en_i || fifo_empty_i) checkOutput("rd_block", {31'd0, fifo_rd_en_o}, 32'd0);
            prev_valid = byte_valid_o;
            prev_ready = byte_ready_i;
            prev_byte  = byte_o;
            prev_rd    = fifo_rd_en_o;
        end
        rd      = fifo_rd_en_o;
        last_rd = rd;
        @(posedge clk_i);
        #1;
        if (rd && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
        fifo_empty_i = (fifo_q.size() == 0);
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic en, input logic ready);
        en_i         = en;
        byte_ready_i = ready;
        step_cycle();
    endtask

    task automatic wait_idle(input int limit);
        int cyc;
        cyc = 0;
        while (!(exp_q.size() == 0 && !busy_o && fifo_q.size() == 0) && cyc < limit) begin
            applyStimulus(1'b1, 1'b1);
            cyc++;
        end
        checkOutput("drain_done", {31'd0, exp_q.size() == 0 && !busy_o && fifo_q.size() == 0}, 32'd1);
    endtask

    initial begin
        int          cyc;
        int          base;
        int          emitted;
        logic [31:0] expw;
        logic [7:0]  bp_byte;

        vecs[0] = '{32'h1234ABCD, 32'h1234ABCD, 32'h92346BCD};
        vecs[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h9EAD7EEF};
        vecs[2] = '{32'hFFFF0000, 32'hFFFF0000, 32'hBFFF4000};
        vecs[3] = '{32'h00000000, 32'h00000000, 32'h80004000};
        vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 32'h80007FFF};
`ifdef IQ_SYNC_BITS_EN
        bp_byte = 8'h7E;
`else
        bp_byte = 8'hBE;
`endif

        errors       = 0;
        checks       = 0;
        byte_cnt     = 0;
        prev_valid   = 1'b0;
        prev_ready   = 1'b0;
        prev_byte    = 8'h00;
        prev_rd      = 1'b0;
        last_rd      = 1'b0;
        rst_i        = 1'b1;
        en_i         = 1'b0;
        byte_ready_i = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 32'h0;

        @(negedge clk_i);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("reset_valid", {31'd0, byte_valid_o}, 32'd0);
        checkOutput("reset_byte", {24'd0, byte_o}, 32'd0);
        checkOutput("reset_sos", {31'd0, sample_start_o}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_rd", {31'd0, fifo_rd_en_o}, 32'd0);
        rst_i = 1'b0;
        applyStimulus(1'b1, 1'b1);

        // Single words from the table: read pulse, fixed latency, four
        // consecutive bytes, then idle.
        for (int i = 0; i < 5; i++) begin
`ifdef IQ_SYNC_BITS_EN
            expw = vecs[i].exp_sync;
`else
            expw = vecs[i].exp_plain;
`endif
            push_word(vecs[i].word, expw);
            cyc = 0;
            do begin
                applyStimulus(1'b1, 1'b1);
                cyc++;
            end while (!last_rd && cyc < 10);
            checkOutput("vec_rd", {31'd0, last_rd}, 32'd1);
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b1, 1'b1);
            for (int k = 0; k < NB; k++) begin
                checkOutput("vec_valid", {31'd0, byte_valid_o}, 32'd1);
                checkOutput("vec_byte", {24'd0, byte_o}, {24'd0, expw[31-8*k -: 8]});
                checkOutput("vec_sos", {31'd0, sample_start_o}, {31'd0, k == 0});
                applyStimulus(1'b1, 1'b1);
            end
            checkOutput("vec_end_valid", {31'd0, byte_valid_o}, 32'd0);
            checkOutput("vec_end_busy", {31'd0, busy_o}, 32'd0);
        end

        // Three queued words stream as twelve gapless bytes.
        base = byte_cnt;
        push_word(32'hA1B2C3D4, shape_word(32'hA1B2C3D4));
        push_word(32'h0F1E2D3C, shape_word(32'h0F1E2D3C));
        push_word(32'h55AA33CC, shape_word(32'h55AA33CC));
        cyc = 0;
        while (!byte_valid_o && cyc < 10) begin
            applyStimulus(1'b1, 1'b1);
            cyc++;
        end
        for (int k = 0; k < 3 * NB; k++) begin
            checkOutput("b2b_valid", {31'd0, byte_valid_o}, 32'd1);
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("b2b_end", {31'd0, byte_valid_o}, 32'd0);
        checkOutput("b2b_total", byte_cnt - base, 32'd12);

        // Backpressure on the third byte of 0xDEADBEEF.
        base = byte_cnt;
        push_word(32'hDEADBEEF, shape_word(32'hDEADBEEF));
        cyc = 0;
        while (byte_cnt - base < 2 && cyc < 20) begin
            applyStimulus(1'b1, 1'b1);
            cyc++;
        end
        checkOutput("bp_reach", byte_cnt - base, 32'd2);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_byte", {24'd0, byte_o}, {24'd0, bp_byte});
            checkOutput("bp_valid", {31'd0, byte_valid_o}, 32'd1);
            applyStimulus(1'b1, 1'b0);
        end
        wait_idle(20);
        checkOutput("bp_total", byte_cnt - base, 32'd4);

        // Dropping en_i during byte 1 lets in-flight words finish only.
        base = byte_cnt;
        for (int k = 0; k < 4; k++) push_word(32'h10203040 + k, shape_word(32'h10203040 + k));
        cyc = 0;
        while (byte_cnt - base < 1 && cyc < 20) begin
            applyStimulus(1'b1, 1'b1);
            cyc++;
        end
        for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b1);
        emitted = byte_cnt - base;
        checkOutput("en_words", {31'd0, emitted == 4 || emitted == 8}, 32'd1);
        checkOutput("en_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("en_fifo_left", {31'd0, fifo_q.size() >= 2}, 32'd1);
        wait_idle(100);
        checkOutput("en_total", byte_cnt - base, 32'd16);

        // Reset after byte 1 of 0x1234ABCD discards the rest of the word.
        base = byte_cnt;
        push_word(32'h1234ABCD, shape_word(32'h1234ABCD));
        cyc = 0;
        while (byte_cnt - base < 2 && cyc < 20) begin
            applyStimulus(1'b1, 1'b1);
            cyc++;
        end
        checkOutput("rst_reach", byte_cnt - base, 32'd2);
        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b1);
        rst_i = 1'b0;
        exp_q.delete();
        byte_cnt = 0;
        checkOutput("rst_mid_valid", {31'd0, byte_valid_o}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("rst_quiet", {31'd0, byte_valid_o}, 32'd0);
        end
        push_word(32'hCAFEF00D, shape_word(32'hCAFEF00D));
        wait_idle(20);

        // Randomized traffic against the stream model.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] w;
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) begin
                w = $urandom;
                push_word(w, shape_word(w));
            end
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
        end
        wait_idle(300);
        checkOutput("rand_left", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
